memristor_pv_ctrl: RTL and testbench

- Digital program-and-verify controller that sits directly upstream of the memristor device model.
- Drives the cell's programming and read voltage through a signed DAC code plus a drive enable.
- Samples the cell read current through an external ADC handshake.
- Iterates SET/RESET pulses until the read current crosses a target or a retry limit is hit, then reports one response per command.

---
 rtl/memristor_pv_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_memristor_pv_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memristor_pv_ctrl.sv
// Program-and-verify controller for one memristor cell: SET/RESET pulses, read-bias verify, one response per command.
// Optional incremental step pulse programming is enabled by defining PV_PULSE_RAMP_EN.
module memristor_pv_ctrl #(
  parameter int                      DAC_W      = 8,
  parameter int                      ADC_W      = 10,
  parameter logic signed [DAC_W-1:0] V_SET      = 8'sd96,
  parameter logic signed [DAC_W-1:0] V_RESET    = -8'sd112,
  parameter logic signed [DAC_W-1:0] V_READ     = 8'sd16,
  parameter int                      PULSE_CYC  = 16,
  parameter int                      SETTLE_CYC = 4,
  parameter int                      ADC_TO     = 64,
  parameter int                      MAX_TRIES  = 8,
  parameter logic signed [DAC_W-1:0] V_STEP     = 8'sd8,
  parameter logic signed [DAC_W-1:0] V_MAX      = 8'sd127
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [1:0]              cmd_op_i,
  input  logic [ADC_W-1:0]        cmd_target_i,
  output logic                    drive_en_o,
  output logic signed [DAC_W-1:0] dac_code_o,
  output logic                    adc_start_o,
  input  logic                    adc_valid_i,
  input  logic [ADC_W-1:0]        adc_data_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ADC_W-1:0]        rsp_data_o,
  output logic [1:0]              rsp_status_o,
  output logic [3:0]              rsp_tries_o,
  output logic                    busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_PULSE, S_SETTLE, S_SAMPLE, S_CHECK, S_RESP} state_e;
  typedef enum logic [1:0] {OP_READ, OP_SET, OP_RESET, OP_ILLEGAL} op_e;
  typedef enum logic [1:0] {ST_OK, ST_VERIFY_FAIL, ST_ADC_TIMEOUT, ST_ILLEGAL_OP} status_e;

  localparam int CNT_MAX = (PULSE_CYC > ADC_TO) ? PULSE_CYC : ADC_TO;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [ADC_W-1:0] target_q, target_d;
  logic [3:0]       tries_q, tries_d;
  logic [ADC_W-1:0] data_q, data_d;
  status_e          status_q, status_d;
  logic signed [DAC_W-1:0] pulse_code;
  logic             verify_pass;

  // NOTE: state uses non-blocking assignments so every register samples the pre-edge value of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_READ;
      target_q <= '0;
      tries_q  <= '0;
      data_q   <= '0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      target_q <= target_d;
      tries_q  <= tries_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

`ifdef PV_PULSE_RAMP_EN
  localparam logic signed [DAC_W+3:0] SET_W  = (DAC_W+4)'(V_SET);
  localparam logic signed [DAC_W+3:0] RST_W  = (DAC_W+4)'(V_RESET);
  localparam logic signed [DAC_W+3:0] STEP_W = (DAC_W+4)'(V_STEP);
  localparam logic signed [DAC_W+3:0] MAX_W  = (DAC_W+4)'(V_MAX);
  logic signed [DAC_W+3:0] step_w, ramp_w;

  // Try n adds (n-1) steps of magnitude, clamped to +/-V_MAX before narrowing.
  always_comb begin
    step_w = $signed({{DAC_W{1'b0}}, tries_q - 4'd1}) * STEP_W;
    if (op_q == OP_SET) begin
      ramp_w = SET_W + step_w;
      if (ramp_w > MAX_W) ramp_w = MAX_W;
    end else begin
      ramp_w = RST_W - step_w;
      if (ramp_w < -MAX_W) ramp_w = -MAX_W;
    end
    pulse_code = ramp_w[DAC_W-1:0];
  end
`else
  assign pulse_code = (op_q == OP_SET) ? V_SET : V_RESET;
`endif

  assign verify_pass = (op_q == OP_SET) ? (data_q >= target_q) : (data_q <= target_q);

  // NOTE: every signal gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    op_d     = op_q;
    target_d = target_q;
    tries_d  = tries_q;
    data_d   = data_q;
    status_d = status_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cmd_valid_i) begin
          op_d     = op_e'(cmd_op_i);
          target_d = cmd_target_i;
          tries_d  = '0;
          status_d = ST_OK;
          unique case (op_e'(cmd_op_i))
            OP_READ:          state_d = S_SETTLE;
            OP_SET, OP_RESET: begin state_d = S_PULSE; tries_d = 4'd1; end
            OP_ILLEGAL:       begin state_d = S_CHECK; status_d = ST_ILLEGAL_OP; data_d = '0; end
          endcase
        end
      end
      S_PULSE:  if (cnt_q == CNT_W'(PULSE_CYC - 1))  begin state_d = S_SETTLE; cnt_d = '0; end
      S_SETTLE: if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin state_d = S_SAMPLE; cnt_d = '0; end
      S_SAMPLE: begin
        // Timeout lands RESP exactly ADC_TO cycles after the adc_start cycle.
        if (adc_valid_i) begin
          data_d  = adc_data_i;
          state_d = S_CHECK;
        end else if (cnt_q == CNT_W'(ADC_TO - 2)) begin
          status_d = ST_ADC_TIMEOUT;
          state_d  = S_RESP;
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (op_q == OP_ILLEGAL) begin
          state_d = S_RESP;
        end else if (op_q == OP_READ || verify_pass) begin
          status_d = ST_OK;
          state_d  = S_RESP;
        end else if (tries_q == 4'(MAX_TRIES)) begin
          status_d = ST_VERIFY_FAIL;
          state_d  = S_RESP;
        end else begin
          tries_d = tries_q + 4'd1;
          state_d = S_PULSE;
        end
      end
      S_RESP: begin
        cnt_d = '0;
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    drive_en_o  = 1'b0;
    dac_code_o  = '0;
    adc_start_o = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      S_PULSE:  begin drive_en_o = 1'b1; dac_code_o = pulse_code; end
      S_SETTLE: begin
        drive_en_o  = 1'b1;
        dac_code_o  = V_READ;
        adc_start_o = (cnt_q == CNT_W'(SETTLE_CYC - 1));
      end
      S_SAMPLE: begin drive_en_o = 1'b1; dac_code_o = V_READ; end
      S_RESP:   rsp_valid_o = 1'b1;
      default:  ;
    endcase
  end

  assign cmd_ready_o  = (state_q == S_IDLE) && !rst;
  assign busy_o       = (state_q != S_IDLE);
  assign rsp_data_o   = data_q;
  assign rsp_status_o = status_q;
  assign rsp_tries_o  = tries_q;

endmodule

// File: tb/tb_memristor_pv_ctrl.sv
// Self-checking bench for memristor_pv_ctrl: per-cycle trace model plus literal pins on key results.
module tb_memristor_pv_ctrl;

  localparam int PULSE_CYC = 16, SETTLE_CYC = 4, ADC_TO = 64, MAX_TRIES = 8;
  localparam int V_SET = 96, V_RESET = -112, V_READ = 16, V_STEP = 8, V_MAX = 127;

  logic              clk = 1'b0, rst = 1'b1;
  logic              cmd_valid = 1'b0, cmd_ready;
  logic [1:0]        cmd_op = 2'd0;
  logic [9:0]        cmd_target = '0;
  logic              drive_en, adc_start, busy;
  logic signed [7:0] dac_code;
  logic              adc_valid = 1'b0;
  logic [9:0]        adc_data = '0;
  logic              rsp_valid, rsp_ready = 1'b0;
  logic [9:0]        rsp_data;
  logic [1:0]        rsp_status;
  logic [3:0]        rsp_tries;

  memristor_pv_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op), .cmd_target_i(cmd_target),
    .drive_en_o(drive_en), .dac_code_o(dac_code), .adc_start_o(adc_start),
    .adc_valid_i(adc_valid), .adc_data_i(adc_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_status_o(rsp_status), .rsp_tries_o(rsp_tries), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit drv; int dac; bit st; bit busy; bit rv; int rd; int rs; int rt;
  } exp_t;

  exp_t exp_q[$];
  int   stim_codes[$], adc_q[$];
  int   adc_lat = 1;
  int   m_data = 0;
  int   n_vec = 0, n_err = 0;
  int   cyc = 0;
  bit   running = 1'b0;
  int   t_acc, t_start, t_rsp, got_data, got_status, got_tries, pulse_cyc;
  bit   seen_rsp, prev_pulse;
  int   pulse_codes[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pcode(input int op, input int n);
`ifdef PV_PULSE_RAMP_EN
    int v;
    if (op == 1) begin
      v = V_SET + (n - 1) * V_STEP;
      if (v > V_MAX) v = V_MAX;
    end else begin
      v = V_RESET - (n - 1) * V_STEP;
      if (v < -V_MAX) v = -V_MAX;
    end
    return v;
`else
    return (op == 1) ? V_SET : V_RESET;
`endif
  endfunction

  task automatic push(input bit drv, input int dac, input bit st, input bit bsy,
                      input bit rv, input int rd, input int rs, input int rt);
    exp_t e;
    e.drv = drv; e.dac = dac; e.st = st; e.busy = bsy;
    e.rv = rv; e.rd = rd; e.rs = rs; e.rt = rt;
    exp_q.push_back(e);
  endtask

  // Expected per-cycle trace from the cycle after acceptance until the response is taken.
  task automatic build(input int op, input int target, input int lat, input int d);
    int codes[$];
    int tries, st;
    bit done;
    codes = stim_codes;
    tries = 0; st = 0; done = 1'b0;
    if (op == 3) begin
      push(0, 0, 0, 1, 0, 0, 0, 0);
      st = 3; m_data = 0;
    end else begin
      while (!done) begin
        if (op != 0) begin
          tries++;
          for (int i = 0; i < PULSE_CYC; i++) push(1, pcode(op, tries), 0, 1, 0, 0, 0, 0);
        end
        for (int i = 0; i < SETTLE_CYC; i++) push(1, V_READ, (i == SETTLE_CYC - 1), 1, 0, 0, 0, 0);
        if (codes.size() == 0) begin
          for (int i = 0; i < ADC_TO - 1; i++) push(1, V_READ, 0, 1, 0, 0, 0, 0);
          st = 2; done = 1'b1;
        end else begin
          for (int i = 0; i < lat; i++) push(1, V_READ, 0, 1, 0, 0, 0, 0);
          m_data = codes.pop_front();
          push(0, 0, 0, 1, 0, 0, 0, 0);
          if (op == 0 || (op == 1 && m_data >= target) || (op == 2 && m_data <= target)) begin
            st = 0; done = 1'b1;
          end else if (tries == MAX_TRIES) begin
            st = 1; done = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i <= d; i++) push(0, 0, 0, 1, 1, m_data, st, tries);
  endtask

  // Compare every cycle against the trace; an empty trace means the block must be idle.
  always @(negedge clk) begin
    if (running && !rst) begin
      exp_t e;
      bit   ok, is_p;
      e = '{default: 0};
      if (exp_q.size() > 0) e = exp_q.pop_front();
      ok = (drive_en == e.drv) && (int'(dac_code) == e.dac) && (adc_start == e.st) &&
           (busy == e.busy) && (cmd_ready == !e.busy) && (rsp_valid == e.rv);
      if (e.rv)
        ok = ok && (int'(rsp_data) == e.rd) && (int'(rsp_status) == e.rs) && (int'(rsp_tries) == e.rt);
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL cycle %0d trace: got drv=%0b dac=%0d start=%0b busy=%0b rdy=%0b rv=%0b data=%0d st=%0d tries=%0d expected drv=%0b dac=%0d start=%0b busy=%0b rv=%0b data=%0d st=%0d tries=%0d",
                 cyc, drive_en, dac_code, adc_start, busy, cmd_ready, rsp_valid, rsp_data, rsp_status,
                 rsp_tries, e.drv, e.dac, e.st, e.busy, e.rv, e.rd, e.rs, e.rt);
      end
      if (adc_start) t_start = cyc;
      if (rsp_valid && !seen_rsp) begin
        seen_rsp = 1'b1; t_rsp = cyc;
        got_data = int'(rsp_data); got_status = int'(rsp_status); got_tries = int'(rsp_tries);
      end
      is_p = drive_en && (int'(dac_code) != V_READ);
      if (is_p) pulse_cyc++;
      if (is_p && !prev_pulse) pulse_codes.push_back(int'(dac_code));
      prev_pulse = is_p;
    end
  end

  // ADC responder: answers each adc_start after adc_lat cycles with the next scripted code.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (adc_start && adc_q.size() > 0) begin
        for (int k = 0; k < adc_lat; k++) begin @(posedge clk); #1; end
        adc_data  = 10'(adc_q.pop_front());
        adc_valid = 1'b1;
        @(posedge clk); #1;
        adc_valid = 1'b0;
      end
    end
  end

  task automatic run_cmd(input int op, input int target, input int lat, input int d);
    bit found;
    seen_rsp = 1'b0; pulse_cyc = 0; prev_pulse = 1'b0; pulse_codes.delete();
    t_start = -1; t_rsp = -1;
    adc_q = stim_codes; adc_lat = lat;
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_target = 10'(target);
    t_acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    build(op, target, lat, d);
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (rsp_valid) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!found) check("rsp_wait_timeout", 0, 1);
    repeat (d) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_drive_en", int'(drive_en), 0);
    check("rst_dac_code", int'(dac_code), 0);
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_adc_start", int'(adc_start), 0);
    check("rst_rsp_fields", int'({rsp_data, rsp_status, rsp_tries}), 0);
    #21 rst = 1'b0;
    @(posedge clk); #1;
    running = 1'b1;

    stim_codes = '{300};
    run_cmd(0, 0, 1, 0);
    check("read_data", got_data, 300);
    check("read_status", got_status, 0);
    check("read_tries", got_tries, 0);
    check("read_start_lat", t_start - t_acc, SETTLE_CYC);
    check("read_rsp_lat", t_rsp - t_acc, SETTLE_CYC + 3);
    check("read_no_pulse", pulse_cyc, 0);

    stim_codes = '{200, 400, 520};
    run_cmd(1, 500, 1, 0);
    check("set_data", got_data, 520);
    check("set_status", got_status, 0);
    check("set_tries", got_tries, 3);
    check("set_pulse_cycles", pulse_cyc, 48);
    check("set_pulse_code", pulse_codes.size() > 0 ? pulse_codes[0] : 0, 96);

    stim_codes = '{500};
    run_cmd(1, 500, 1, 0);
    check("set_eq_target_status", got_status, 0);
    check("set_eq_target_tries", got_tries, 1);

    stim_codes = '{100};
    run_cmd(2, 100, 1, 0);
    check("reset_eq_target_status", got_status, 0);

    stim_codes = '{400, 400, 400, 400, 400, 400, 400, 400};
    run_cmd(2, 100, 1, 0);
    check("reset_fail_status", got_status, 1);
    check("reset_fail_tries", got_tries, 8);
    check("reset_fail_data", got_data, 400);
    check("reset_fail_npulses", pulse_codes.size(), 8);
`ifndef PV_PULSE_RAMP_EN
    check("reset_fail_code", pulse_codes.size() > 7 ? pulse_codes[7] : 0, -112);
`endif

    stim_codes.delete();
    run_cmd(1, 500, 1, 0);
    check("timeout_status", got_status, 2);
    check("timeout_tries", got_tries, 1);
    check("timeout_lat", t_rsp - t_start, 64);

    run_cmd(3, 0, 1, 0);
    check("illegal_status", got_status, 3);
    check("illegal_lat", t_rsp - t_acc, 2);
    check("illegal_data", got_data, 0);

    stim_codes.delete();
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_target = 10'd500;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    build(1, 500, 1, 0);
    repeat (5) begin @(posedge clk); #1; end
    check("pre_rst_in_pulse", int'(drive_en), 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_drive_en", int'(drive_en), 0);
    check("midrst_dac_code", int'(dac_code), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_rsp_valid", int'(rsp_valid), 0);
    exp_q.delete(); adc_q.delete(); m_data = 0;
    @(negedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;

    stim_codes = '{10, 10, 10, 10, 10, 10, 10, 10};
    run_cmd(1, 1023, 1, 5);
    check("setfail_status", got_status, 1);
    check("setfail_tries", got_tries, 8);
    check("setfail_data", got_data, 10);
    begin
`ifdef PV_PULSE_RAMP_EN
      int want[8] = '{96, 104, 112, 120, 127, 127, 127, 127};
`else
      int want[8] = '{96, 96, 96, 96, 96, 96, 96, 96};
`endif
      check("setfail_npulses", pulse_codes.size(), 8);
      for (int i = 0; i < 8; i++)
        check($sformatf("setfail_code%0d", i), pulse_codes.size() > i ? pulse_codes[i] : 0, want[i]);
    end

    repeat (3) @(posedge clk);
    #1;
    check("trace_drained", exp_q.size(), 0);
    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
